k12a_spi_regs: RTL and testbench
================================

Name: k12a_spi_regs

Overview:
Register stage directly downstream of the SPI control FSM. It holds the SPI state register, the transfer bit counter, the 8-bit data shift register, the SCK/MOSI/SS_N pin registers and the MISO sample latch. It applies the FSM's tick, select, store and next-state outputs on each CPU clock edge, and feeds back spi_state, spi_counter_zero and spi_sck to the FSM. It presents the data register to the IO read path.

Parameters:
DATA_WIDTH, 8, shift register width; fixed at 8 for the K12A IO map
COUNTER_WIDTH, 4, bit counter width; must satisfy 2^COUNTER_WIDTH = 2*DATA_WIDTH

Ports:
clock  input  1  CPU clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
spi_counter_tick  input  1  from FSM: decrement counter this edge
spi_data_sel  input  1  from FSM (spi_data_sel_t): 0 = SPI_DATA_SEL_DATA_BUS, 1 = SPI_DATA_SEL_SHIFT
spi_data_store  input  1  from FSM: load data register this edge
spi_next_state  input  1  from FSM (spi_state_t): 0 = SPI_STATE_IDLE, 1 = SPI_STATE_XFER
spi_data_in  input  DATA_WIDTH  CPU data bus value for an IO data write
spi_ss_store  input  1  decoded IO write to the slave-select register
spi_ss_in  input  1  value for SS_N on spi_ss_store
spi_miso  input  1  MISO pin
spi_state  output  1  current FSM state
spi_counter_zero  output  1  counter == 0
spi_sck  output  1  SCK pin; also fed back to the FSM
spi_mosi  output  1  MOSI pin
spi_ss_n  output  1  slave select, active low
spi_data_out  output  DATA_WIDTH  data register contents, for IO reads
spi_busy  output  1  spi_state == SPI_STATE_XFER

Behaviour:
- Reset values (synchronous, take priority over every other update):
  - state = IDLE, counter = 0, data = 0x00
  - sck = 0, miso_latch = 0, ss_n = 1
  - therefore mosi = 0, spi_busy = 0, spi_counter_zero = 1
- Reset mid-transfer aborts the transfer immediately: next cycle IDLE, sck low, ss_n high. No partial-byte recovery.
- State register: state <= spi_next_state on every edge.
- Counter:
  - if spi_counter_tick, counter <= counter - 1, modulo 2^COUNTER_WIDTH (0 wraps to 15); otherwise hold.
  - spi_counter_zero is combinational from the counter.
- SCK:
  - toggles on every edge where the current spi_state == XFER; held otherwise.
  - A transfer starts with sck = 0 (SPI mode 0).
- MISO sampling: on each edge where state == XFER and sck == 0 (the SCK rising-edge event), miso_latch <= spi_miso. Otherwise hold.
- Data register:
  - if spi_data_store and sel = DATA_BUS, data <= spi_data_in.
  - if spi_data_store and sel = SHIFT, data <= {data[6:0], miso_latch}.
  - otherwise hold.
- MOSI = data[7], combinational from the register, so it is stable before each SCK rising edge.
- SS_N: if spi_ss_store, ss_n <= spi_ss_in. Independent of state; a write during XFER takes effect next edge and does not abort the transfer.
- Transfer timing:
  - begin edge: IDLE with tick; counter goes 0→15, state → XFER.
  - XFER occupies exactly 16 cycles (counter 15..0) and gives 8 SCK pulses.
  - 8 shifts occur, each on an SCK falling edge.
  - On the last edge, state → IDLE and sck returns to 0.
  - spi_busy is high for 16 cycles.
- Simultaneous events: tick, store and state update are independent and all apply on the same edge. Store with sel = DATA_BUS during XFER is not generated by the FSM; if presented, it is applied as written.

Optional Feature:
K12A_SPI_LSB_FIRST_EN
- Defined: shift becomes data <= {miso_latch, data[7:1]} and MOSI = data[0].
- Undefined: MSB-first, as above.
- Timing, counter and SCK behaviour are identical in both builds.

Test Plan:
- Reset: assert reset 1 cycle mid-XFER with sck = 1 → next cycle state = IDLE, sck = 0, ss_n = 1, data = 0x00, counter_zero = 1.
- Data write: store, sel = DATA_BUS, data_in = 0xA5 → data_out = 0xA5, mosi = 1.
- Full transfer:
  - setup: data = 0xA5, ss_in = 0 stored, FSM-driven begin; MISO bit set up before each SCK rising edge with 0x3C, MSB-first.
  - required: exactly 8 SCK pulses.
  - required: MOSI sampled at SCK rising edges = 1,0,1,0,0,1,0,1.
  - required: data_out = 0x3C when busy falls; busy high exactly 16 cycles.
- Counter wrap: tick with counter = 0 → 15; 15 further ticks → counter_zero = 1.
- SS write during XFER: ss_in = 1 mid-transfer → ss_n = 1 next cycle, transfer completes all 16 cycles.
- LSB-first build: data = 0xA5, MISO = 0x3C sent LSB-first → MOSI = 1,0,1,0,0,1,0,1 (LSB-first order), final data_out = 0x3C.

Source files
------------

// File: rtl/k12a_spi_regs.sv
// K12A SPI register stage: state, bit counter, data shift register and pin registers behind the SPI FSM.
// Build option K12A_SPI_LSB_FIRST_EN selects LSB-first shifting; MSB-first when undefined.
module k12a_spi_regs #(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_counter_tick,
  input  logic                  spi_data_sel,
  input  logic                  spi_data_store,
  input  logic                  spi_next_state,
  input  logic [DATA_WIDTH-1:0] spi_data_in,
  input  logic                  spi_ss_store,
  input  logic                  spi_ss_in,
  input  logic                  spi_miso,
  output logic                  spi_state,
  output logic                  spi_counter_zero,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  output logic                  spi_ss_n,
  output logic [DATA_WIDTH-1:0] spi_data_out,
  output logic                  spi_busy
);

  typedef enum logic {
    SPI_STATE_IDLE = 1'b0,
    SPI_STATE_XFER = 1'b1
  } spi_state_t;

  typedef enum logic {
    SPI_DATA_SEL_DATA_BUS = 1'b0,
    SPI_DATA_SEL_SHIFT    = 1'b1
  } spi_data_sel_t;

  spi_state_t               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     sck_q, sck_d;
  logic                     miso_q, miso_d;
  logic                     ss_n_q, ss_n_d;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] d,
                                                     input logic b);
`ifdef K12A_SPI_LSB_FIRST_EN
    return {b, d[DATA_WIDTH-1:1]};
`else
    return {d[DATA_WIDTH-2:0], b};
`endif
  endfunction

  always_comb begin
    state_d   = spi_state_t'(spi_next_state);
    counter_d = counter_q;
    data_d    = data_q;
    sck_d     = sck_q;
    miso_d    = miso_q;
    ss_n_d    = ss_n_q;
    if (spi_counter_tick) counter_d = counter_q - COUNTER_WIDTH'(1);
    if (state_q == SPI_STATE_XFER) begin
      sck_d = ~sck_q;
      // sck low here means this edge raises SCK: sample MISO now
      if (!sck_q) miso_d = spi_miso;
    end
    if (spi_data_store) begin
      if (spi_data_sel_t'(spi_data_sel) == SPI_DATA_SEL_SHIFT) data_d = shift_in(data_q, miso_q);
      else                                                     data_d = spi_data_in;
    end
    if (spi_ss_store) ss_n_d = spi_ss_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SPI_STATE_IDLE;
      counter_q <= '0;
      data_q    <= '0;
      sck_q     <= 1'b0;
      miso_q    <= 1'b0;
      ss_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      data_q    <= data_d;
      sck_q     <= sck_d;
      miso_q    <= miso_d;
      ss_n_q    <= ss_n_d;
    end
  end

  assign spi_state        = state_q;
  assign spi_counter_zero = (counter_q == '0);
  assign spi_sck          = sck_q;
`ifdef K12A_SPI_LSB_FIRST_EN
  assign spi_mosi         = data_q[0];
`else
  assign spi_mosi         = data_q[DATA_WIDTH-1];
`endif
  assign spi_ss_n         = ss_n_q;
  assign spi_data_out     = data_q;
  assign spi_busy         = (state_q == SPI_STATE_XFER);

endmodule

// File: tb/tb_k12a_spi_regs.sv
// Directed bench for k12a_spi_regs; the bench plays the SPI FSM role and checks against hand-computed values.
module tb_k12a_spi_regs;

  logic       clock = 1'b0;
  logic       reset;
  logic       spi_counter_tick, spi_data_sel, spi_data_store, spi_next_state;
  logic [7:0] spi_data_in;
  logic       spi_ss_store, spi_ss_in, spi_miso;
  logic       spi_state, spi_counter_zero, spi_sck, spi_mosi, spi_ss_n, spi_busy;
  logic [7:0] spi_data_out;

  int n_checks = 0;
  int n_errors = 0;

  k12a_spi_regs #(.DATA_WIDTH(8), .COUNTER_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .spi_counter_tick(spi_counter_tick), .spi_data_sel(spi_data_sel),
    .spi_data_store(spi_data_store), .spi_next_state(spi_next_state),
    .spi_data_in(spi_data_in), .spi_ss_store(spi_ss_store), .spi_ss_in(spi_ss_in),
    .spi_miso(spi_miso), .spi_state(spi_state), .spi_counter_zero(spi_counter_zero),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_data_out(spi_data_out), .spi_busy(spi_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    spi_counter_tick = 1'b0;
    spi_data_sel     = 1'b0;
    spi_data_store   = 1'b0;
    spi_next_state   = 1'b0;
    spi_ss_store     = 1'b0;
  endtask

  task automatic write_data(input logic [7:0] v);
    spi_data_store = 1'b1;
    spi_data_sel   = 1'b0;
    spi_data_in    = v;
    step();
    spi_data_store = 1'b0;
  endtask

  task automatic write_ss(input logic v);
    spi_ss_store = 1'b1;
    spi_ss_in    = v;
    step();
    spi_ss_store = 1'b0;
  endtask

  // Runs one FSM-driven byte transfer; MISO sends 0x3C in the build's bit order.
  task automatic run_xfer(input string tag, input bit ss_mid);
    logic [7:0] miso_pat;
    logic [7:0] mosi_bits;
    int         busy_cyc, pulses, k;
    logic       pre_sck;
    miso_pat  = 8'h3C;
    mosi_bits = 8'h00;
    busy_cyc  = 0;
    pulses    = 0;
    k         = 0;
    spi_counter_tick = 1'b1;
    spi_next_state   = 1'b1;
    spi_data_store   = 1'b0;
    step();
    check({tag, "_begin_busy"}, 32'(spi_busy), 32'd1);
    check({tag, "_begin_sck"}, 32'(spi_sck), 32'd0);
    for (int c = 0; c < 40 && spi_busy; c++) begin
      busy_cyc++;
      pre_sck = spi_sck;
      if (!spi_sck && k < 8) begin
        mosi_bits = {mosi_bits[6:0], spi_mosi};
`ifdef K12A_SPI_LSB_FIRST_EN
        spi_miso = miso_pat[k];
`else
        spi_miso = miso_pat[7-k];
`endif
        k++;
      end
      spi_counter_tick = !spi_counter_zero;
      spi_next_state   = !spi_counter_zero;
      spi_data_store   = spi_sck;
      spi_data_sel     = 1'b1;
      spi_ss_store     = ss_mid && (busy_cyc == 6);
      spi_ss_in        = 1'b1;
      step();
      if (!pre_sck && spi_sck) pulses++;
      if (ss_mid && busy_cyc == 6) begin
        check({tag, "_ss_mid"}, 32'(spi_ss_n), 32'd1);
        check({tag, "_ss_mid_busy"}, 32'(spi_busy), 32'd1);
      end
    end
    idle_inputs();
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd16);
    check({tag, "_sck_pulses"}, 32'(pulses), 32'd8);
    check({tag, "_mosi_bits"}, 32'(mosi_bits), 32'hA5);
    check({tag, "_data_out"}, 32'(spi_data_out), 32'h3C);
    check({tag, "_end_sck"}, 32'(spi_sck), 32'd0);
    check({tag, "_end_zero"}, 32'(spi_counter_zero), 32'd1);
  endtask

  initial begin
    idle_inputs();
    spi_data_in = 8'h00;
    spi_ss_in   = 1'b1;
    spi_miso    = 1'b0;
    reset       = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_state", 32'(spi_state), 32'd0);
    check("rst_zero", 32'(spi_counter_zero), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_ss_n", 32'(spi_ss_n), 32'd1);
    check("rst_data", 32'(spi_data_out), 32'h00);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_busy", 32'(spi_busy), 32'd0);

    write_data(8'hA5);
    check("wr_data", 32'(spi_data_out), 32'hA5);
    check("wr_mosi", 32'(spi_mosi), 32'd1);
    write_data(8'h5A);
`ifdef K12A_SPI_LSB_FIRST_EN
    check("wr_mosi_5a", 32'(spi_mosi), 32'd0);
`else
    check("wr_mosi_5a", 32'(spi_mosi), 32'd0);
`endif
    write_ss(1'b0);
    check("ss_low", 32'(spi_ss_n), 32'd0);

    write_data(8'hA5);
    run_xfer("xfer", 1'b0);
    check("xfer_ss_held", 32'(spi_ss_n), 32'd0);

    write_data(8'hA5);
    run_xfer("xfer_ss", 1'b1);
    check("xfer_ss_end", 32'(spi_ss_n), 32'd1);

    // counter wrap from 0 while idle
    spi_counter_tick = 1'b1;
    spi_next_state   = 1'b0;
    step();
    check("wrap_zero", 32'(spi_counter_zero), 32'd0);
    check("wrap_idle_sck", 32'(spi_sck), 32'd0);
    check("wrap_idle_busy", 32'(spi_busy), 32'd0);
    for (int i = 0; i < 14; i++) step();
    check("wrap_14", 32'(spi_counter_zero), 32'd0);
    step();
    check("wrap_15", 32'(spi_counter_zero), 32'd1);
    idle_inputs();

    // reset asserted mid-transfer with sck high
    write_data(8'hA5);
    write_ss(1'b0);
    spi_counter_tick = 1'b1;
    spi_next_state   = 1'b1;
    step();
    step();
    check("pre_rst_sck", 32'(spi_sck), 32'd1);
    check("pre_rst_busy", 32'(spi_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    check("mid_rst_state", 32'(spi_state), 32'd0);
    check("mid_rst_sck", 32'(spi_sck), 32'd0);
    check("mid_rst_ss_n", 32'(spi_ss_n), 32'd1);
    check("mid_rst_data", 32'(spi_data_out), 32'h00);
    check("mid_rst_zero", 32'(spi_counter_zero), 32'd1);
    step();
    check("post_rst_busy", 32'(spi_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
